// File: rtl/riscv_pkg.sv
// Shared RV32I core package: reset constants and
// inter-stage bundle types for the IF/ID and ID/EX registers.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          REG_AW    = 5;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        valid;
  } if_id_t;

  localparam int IF_ID_W = $bits(if_id_t);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       pcplus4;
    logic [31:0]       rd1;
    logic [31:0]       rd2;
    logic [31:0]       imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              valid;
  } id_ex_t;

  localparam int ID_EX_W = $bits(id_ex_t);

endpackage

// File: rtl/fetch_ifid_stage_if.sv
// Fetch-stage bundle: hazard controls, EX redirect,
// instruction memory bus and decode-side outputs.
interface fetch_ifid_stage_if;
  import riscv_pkg::*;

  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        pcsrc_e;
  logic [31:0] pctarget_e;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;

  modport master (
    output stall_f, stall_d, flush_d,
    output pcsrc_e, pctarget_e,
    input  imem_addr,
    output imem_rdata,
    input  pc_f, instr_d, pc_d,
    input  pcplus4_d, valid_d
  );

  modport slave (
    input  stall_f, stall_d, flush_d,
    input  pcsrc_e, pctarget_e,
    output imem_addr,
    input  imem_rdata,
    output pc_f, instr_d, pc_d,
    output pcplus4_d, valid_d
  );

endinterface

// File: rtl/fetch_ifid_stage_pipe_reg.sv
// Generic pipeline register: sync reset, then clear,
// then load-enable, in that priority order.
module pipe_reg #(
  parameter int         W       = 32,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_rst)
      r_q <= RST_VAL;
    else if (i_clr)
      r_q <= CLR_VAL;
    else if (i_en)
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch stage: PC register, next-PC select
// and the IF/ID pipeline register feeding decode.
module fetch_ifid_stage #(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR,
  parameter int          XLEN      = riscv_pkg::XLEN
) (
  input logic               clk,
  input logic               reset,
  fetch_ifid_stage_if.slave ifc
);
  import riscv_pkg::if_id_t;
  import riscv_pkg::IF_ID_W;

  if (XLEN != 32) begin : g_xlen_chk
    $error("fetch_ifid_stage: only XLEN=32");
  end

  localparam if_id_t IFID_NOP = '{
    instr:   NOP_INSTR,
    pc:      32'h0,
    pcplus4: 32'h0,
    valid:   1'b0
  };

  logic [31:0] w_pc;
  logic [31:0] w_pcplus4_f;
  logic [31:0] w_pc_next;
  logic        w_pc_en;
  if_id_t      w_ifid_d;
  if_id_t      w_ifid_q;

  assign w_pcplus4_f = w_pc + 32'd4;

  // Redirect must win over stall_f or a taken branch is lost.
  assign w_pc_en   = ~ifc.stall_f | ifc.pcsrc_e;
  assign w_pc_next = ifc.pcsrc_e
                   ? {ifc.pctarget_e[31:2], 2'b00}
                   : w_pcplus4_f;

  pipe_reg #(
    .W       (32),
    .RST_VAL (RESET_PC),
    .CLR_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .i_rst (reset),
    .i_en  (w_pc_en),
    .i_clr (1'b0),
    .i_d   (w_pc_next),
    .o_q   (w_pc)
  );

  always_comb begin
    w_ifid_d         = IFID_NOP;
    w_ifid_d.instr   = ifc.imem_rdata;
    w_ifid_d.pc      = w_pc;
    w_ifid_d.pcplus4 = w_pcplus4_f;
    w_ifid_d.valid   = 1'b1;
  end

  pipe_reg #(
    .W       (IF_ID_W),
    .RST_VAL (IFID_NOP),
    .CLR_VAL (IFID_NOP)
  ) u_ifid_reg (
    .clk   (clk),
    .i_rst (reset),
    .i_en  (~ifc.stall_d),
    .i_clr (ifc.flush_d),
    .i_d   (w_ifid_d),
    .o_q   (w_ifid_q)
  );

  assign ifc.imem_addr = w_pc;
  assign ifc.pc_f      = w_pc;
  assign ifc.instr_d   = w_ifid_q.instr;
  assign ifc.pc_d      = w_ifid_q.pc;
  assign ifc.pcplus4_d = w_ifid_q.pcplus4;
  assign ifc.valid_d   = w_ifid_q.valid;

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I core.
- Holds the PC and selects the next PC: sequential PC+4, or a redirect target resolved in EX.
- Addresses the combinational instruction memory.
- Registers instruction, PC and PC+4 into the decode stage, where the immediate extender and register file consume them.
- Supports load-use stalls from the hazard unit and branch/jump flushes.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction injected on flush/reset (addi x0,x0,0)
XLEN, 32, datapath width; only 32 is supported

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall_f  input  1  hold PC (hazard unit)
stall_d  input  1  hold IF/ID register contents (hazard unit)
flush_d  input  1  replace IF/ID contents with NOP on next edge
pcsrc_e  input  1  redirect taken (branch taken / JAL / JALR, resolved in EX)
pctarget_e  input  32  redirect target from EX
imem_addr  output  32  instruction memory address (= current PC, combinational from PC register)
imem_rdata  input  32  instruction word, valid in the same cycle as imem_addr
pc_f  output  32  current fetch PC
instr_d  output  32  instruction in decode
pc_d  output  32  PC of instr_d
pcplus4_d  output  32  pc_d + 4
valid_d  output  1  1 = instr_d is a real fetched instruction, 0 = bubble

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on the rising edge of clk.
  - Synchronous reset, active high: on a reset edge, PC <= RESET_PC, instr_d <= NOP_INSTR, pc_d <= 0, pcplus4_d <= 0, valid_d <= 0.
  - Reset has priority over every other input, including mid-stall and mid-redirect.
- Fetch: imem_addr = pc_f = PC register. pcplus4_f = PC + 4, modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is silent.
- Next-PC priority, evaluated at each edge:
  1. reset.
  2. pcsrc_e: PC <= {pctarget_e[31:2], 2'b00}. Redirect overrides stall_f, so a simultaneous stall never loses a branch.
  3. stall_f: PC holds.
  4. Otherwise PC <= pcplus4_f.
- IF/ID register priority, evaluated at each edge:
  1. reset.
  2. flush_d: instr_d <= NOP_INSTR, valid_d <= 0, pc_d/pcplus4_d <= 0. Flush beats stall_d.
  3. stall_d: all IF/ID outputs hold.
  4. Otherwise instr_d <= imem_rdata, pc_d <= PC, pcplus4_d <= pcplus4_f, valid_d <= 1.
- Latency:
  - Instruction at PC appears on instr_d one cycle after PC is presented.
  - A redirect asserted in cycle N makes pc_f = target in cycle N+1; the target instruction reaches instr_d in cycle N+2.
- Flush rule: the hazard unit asserts flush_d together with pcsrc_e. The block does not infer flushes from pcsrc_e.
- No internal FSM beyond the PC and IF/ID registers. Target bits [1:0] are discarded; misalignment reporting is out of scope.
- All outputs are registered except imem_addr and pc_f, which are direct copies of the PC register.

Decomposition:
- Shared core package (riscv_pkg) holds:
  - constants NOP_INSTR, RESET_PC and XLEN;
  - the widths used by the IF/ID and ID/EX bundles.
- One natural sub-module: pipe_reg, a parameterised-width register with en/clr/sync reset. It is instantiated for the PC (en = ~stall_f | pcsrc_e) and for the IF/ID bundle (en = ~stall_d, clr = flush_d).
- The adder and next-PC mux stay inline.

Test Plan:
1. Reset then free-run, with imem returning addr-tagged words: pc_f = 0, 4, 8, ...; instr_d lags by one cycle; valid_d = 0 in the first cycle after reset, then 1; pcplus4_d = pc_d + 4.
2. stall_f = stall_d = 1 for 2 cycles at pc_f = 0x10: pc_f holds 0x10, instr_d/pc_d hold the word from 0x0C, then the sequence resumes at 0x14 with no skip or duplicate.
3. pcsrc_e = 1, pctarget_e = 0x100, flush_d = 1 at pc_f = 0x20: next cycle pc_f = 0x100, instr_d = 0x00000013, valid_d = 0; the following cycle instr_d = imem[0x100], pc_d = 0x100.
4. pcsrc_e = 1 with stall_f = 1, stall_d = 1 and flush_d = 1 simultaneously, target 0x40: PC loads 0x40; IF/ID is NOP (flush beats stall).
5. pctarget_e = 0x0000_0206 redirect: pc_f = 0x204. PC preset to 0xFFFF_FFFC then run: next pc_f = 0x0.
6. Reset asserted mid-stall at pc_f = 0x80: next cycle pc_f = RESET_PC, instr_d = NOP, valid_d = 0, regardless of stall/flush inputs.
